// File: rtl/vend_pkg.sv
// Shared types and constants for the coin-operated vending controller.
package vend_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CREDIT = 4'd1,
    ST_VEND   = 4'd2,
    ST_CHANGE = 4'd3,
    ST_REFUND = 4'd4
  } state_e;

  localparam logic [3:0] COIN_F_VAL = 4'd1;
  localparam logic [3:0] COIN_H_VAL = 4'd2;
  localparam logic [3:0] CREDIT_MAX = 4'd15;

  // Both coin pulses in one cycle add together; result is one bit wider to catch overflow.
  function automatic logic [4:0] coin_value(input logic f, input logic h);
    return (f ? {1'b0, COIN_F_VAL} : 5'd0) + (h ? {1'b0, COIN_H_VAL} : 5'd0);
  endfunction

endpackage

// File: rtl/vend_payout.sv
// Coin payout engine: ejects a loaded amount largest coin first, one pulse at most every other cycle.
// Pulses are combinational on hopper_rdy_i; a low hopper_rdy_i stalls with the amount held.
module vend_payout
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [3:0] load_amt_i,
  input  logic       hopper_rdy_i,
  output logic       halfp_o,
  output logic       far_o,
  output logic [3:0] amt_o,
  output logic       done_o
);

  logic [3:0] amt_q, amt_d;
  logic       gap_q, gap_d;
  logic       fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      amt_q <= '0;
      gap_q <= 1'b0;
    end else begin
      amt_q <= amt_d;
      gap_q <= gap_d;
    end
  end

  always_comb begin
    fire    = en_i && !gap_q && hopper_rdy_i && (amt_q != 4'd0);
    halfp_o = fire && (amt_q >= COIN_H_VAL);
    far_o   = fire && (amt_q < COIN_H_VAL);
    amt_d   = amt_q;
    // The cycle after any eject is a forced quiet cycle for the hopper.
    gap_d   = fire && !load_i;
    if (load_i) begin
      amt_d = load_amt_i;
    end else if (halfp_o) begin
      amt_d = amt_q - COIN_H_VAL;
    end else if (far_o) begin
      amt_d = amt_q - COIN_F_VAL;
    end
  end

  assign amt_o  = amt_q;
  assign done_o = (amt_q == 4'd0);

endmodule

// File: rtl/vend_controller.sv
// Vending controller: credit accumulation, vend handshake, change/refund via vend_payout.
// Optional idle-credit timeout forcing a refund is enabled by defining VEND_TIMEOUT_EN.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE       = 3,
  parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       coin_f,
  input  logic       coin_h,
  input  logic       cancel,
  output logic       vend_req,
  input  logic       vend_ack,
  input  logic       hopper_rdy,
  output logic       halfp_out,
  output logic       far_out,
  output logic       coin_reject,
  output logic [3:0] state_code,
  output logic [3:0] credit
);

  if (PRICE < 1 || PRICE > 15 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("vend_controller: PRICE or TIMEOUT_CYC out of range");
  end

  localparam logic [3:0] PRICE_C = 4'(PRICE);

  state_e     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       reject_q, reject_d;
  logic       coin_any;
  logic [4:0] coin_sum;
  logic       timeout_hit;
  logic       pay_en, pay_load, pay_done;
  logic [3:0] pay_load_amt, pay_amt;

  assign coin_any = coin_f || coin_h;
  assign coin_sum = coin_value(coin_f, coin_h);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // An accepted coin always changes credit, so an unchanged credit means an idle cycle.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_CREDIT && state_d == ST_CREDIT && credit_d == credit_q) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  assign timeout_hit = (state_q == ST_CREDIT) && (to_cnt_q == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    reject_d     = 1'b0;
    pay_load     = 1'b0;
    pay_load_amt = '0;
    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (state_q == ST_CREDIT && (cancel || timeout_hit)) begin
          state_d      = ST_REFUND;
          credit_d     = '0;
          pay_load     = 1'b1;
          pay_load_amt = credit_q;
          reject_d     = coin_any;
        end else if (coin_any) begin
          // A coin arriving with cancel is refused even when cancel itself has no effect.
          if (cancel || ({1'b0, credit_q} + coin_sum > {1'b0, CREDIT_MAX})) begin
            reject_d = 1'b1;
          end else begin
            credit_d = credit_q + coin_sum[3:0];
            state_d  = (credit_d >= PRICE_C) ? ST_VEND : ST_CREDIT;
          end
        end
      end
      ST_VEND: begin
        reject_d = coin_any;
        if (vend_ack) begin
          credit_d = '0;
          if (credit_q > PRICE_C) begin
            state_d      = ST_CHANGE;
            pay_load     = 1'b1;
            pay_load_amt = credit_q - PRICE_C;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CHANGE, ST_REFUND: begin
        reject_d = coin_any;
        if (pay_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // While paying out, the displayed credit is whatever the payout engine still owes.
  always_comb begin
    pay_en      = (state_q == ST_CHANGE) || (state_q == ST_REFUND);
    vend_req    = (state_q == ST_VEND);
    state_code  = state_q;
    credit      = pay_en ? pay_amt : credit_q;
    coin_reject = reject_q;
  end

  vend_payout u_payout (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_i        (pay_en),
    .load_i      (pay_load),
    .load_amt_i  (pay_load_amt),
    .hopper_rdy_i(hopper_rdy),
    .halfp_o     (halfp_out),
    .far_o       (far_out),
    .amt_o       (pay_amt),
    .done_o      (pay_done)
  );

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed vector table, corner sequences, random run against a reference model.
module tb_vend_controller;

  localparam int TO = 8;

  logic       clk, reset_n;
  logic       coin_f, coin_h, cancel, vend_ack, hopper_rdy;
  logic       o3_vreq, o3_half, o3_far, o3_rej;
  logic [3:0] o3_st, o3_cr;
  logic       o15_vreq, o15_half, o15_far, o15_rej;
  logic [3:0] o15_st, o15_cr;

  int checks = 0;
  int failures = 0;

  vend_controller #(.PRICE(3), .TIMEOUT_CYC(TO)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .coin_f(coin_f), .coin_h(coin_h), .cancel(cancel),
    .vend_req(o3_vreq), .vend_ack(vend_ack), .hopper_rdy(hopper_rdy),
    .halfp_out(o3_half), .far_out(o3_far), .coin_reject(o3_rej),
    .state_code(o3_st), .credit(o3_cr)
  );

  vend_controller #(.PRICE(15), .TIMEOUT_CYC(TO)) u_dut15 (
    .clk(clk), .reset_n(reset_n), .coin_f(coin_f), .coin_h(coin_h), .cancel(cancel),
    .vend_req(o15_vreq), .vend_ack(vend_ack), .hopper_rdy(hopper_rdy),
    .halfp_out(o15_half), .far_out(o15_far), .coin_reject(o15_rej),
    .state_code(o15_st), .credit(o15_cr)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] cr;
    logic       vreq;
    logic       half;
    logic       far;
    logic       rej;
  } obs_t;

  typedef struct packed {
    logic f, h, c, ack, rdy;
    obs_t exp;
  } vec_t;

  // Reference model: machine phase, owed/held credit, whether the hopper must rest,
  // a pending reject report and how long credit has sat untouched.
  typedef struct {
    int st;
    int cr;
    bit rest;
    bit rej;
    int idle;
  } mdl_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk_obs(input int st, input int cr, input logic vq, input logic hp,
                                  input logic fo, input logic rj);
    return obs_t'({4'(st), 4'(cr), vq, hp, fo, rj});
  endfunction

  function automatic vec_t mk(input logic f, input logic h, input logic c, input logic a,
                              input logic r, input int st, input int cr, input logic vq,
                              input logic hp, input logic fo, input logic rj);
    vec_t v;
    v.f = f; v.h = h; v.c = c; v.ack = a; v.rdy = r;
    v.exp = mk_obs(st, cr, vq, hp, fo, rj);
    return v;
  endfunction

  function automatic obs_t obs3();
    return obs_t'({o3_st, o3_cr, o3_vreq, o3_half, o3_far, o3_rej});
  endfunction

  function automatic obs_t obs15();
    return obs_t'({o15_st, o15_cr, o15_vreq, o15_half, o15_far, o15_rej});
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d cr=%0d vreq=%0b half=%0b far=%0b rej=%0b",
                     o.st, o.cr, o.vreq, o.half, o.far, o.rej);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %s, required %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled at the falling edge.
  task automatic drive(input logic f, input logic h, input logic c, input logic a, input logic r);
    coin_f = f; coin_h = h; cancel = c; vend_ack = a; hopper_rdy = r;
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    coin_f = 0; coin_h = 0; cancel = 0; vend_ack = 0; hopper_rdy = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic obs_t mdl_out(input mdl_t m, input bit rdy);
    obs_t o;
    bit   paying = (m.st == 3 || m.st == 4);
    bit   eject  = paying && !m.rest && rdy && (m.cr > 0);
    o.st   = 4'(m.st);
    o.cr   = 4'(m.cr);
    o.vreq = (m.st == 2);
    o.half = eject && (m.cr >= 2);
    o.far  = eject && (m.cr == 1);
    o.rej  = m.rej;
    return o;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input bit f, input bit h, input bit c,
                                    input bit ack, input bit rdy, input int price);
    mdl_t n = m;
    int   v = (f ? 1 : 0) + (h ? 2 : 0);
    bit   coin = f || h;
    bit   timed_out = 1'b0;
`ifdef VEND_TIMEOUT_EN
    timed_out = (m.st == 1) && (m.idle == TO - 1);
`endif
    n.rej  = 1'b0;
    n.rest = 1'b0;
    if (m.st <= 1) begin
      if (m.st == 1 && (c || timed_out)) begin
        n.st = 4;
        n.rej = coin;
      end else if (coin && (c || m.cr + v > 15)) begin
        n.rej = 1'b1;
      end else if (coin) begin
        n.cr = m.cr + v;
        n.st = (n.cr >= price) ? 2 : 1;
      end
    end else if (m.st == 2) begin
      n.rej = coin;
      if (ack) begin
        n.cr = m.cr - price;
        n.st = (n.cr > 0) ? 3 : 0;
      end
    end else begin
      n.rej = coin;
      if (m.cr == 0) n.st = 0;
      else if (!m.rest && rdy) begin
        n.cr   = m.cr - ((m.cr >= 2) ? 2 : 1);
        n.rest = 1'b1;
      end
    end
    n.idle = (m.st == 1 && n.st == 1 && n.cr == m.cr) ? m.idle + 1 : 0;
    return n;
  endfunction

  vec_t vq[$];
  mdl_t m3, m15;
  int   pcode, last_pc, min_gap, done;

  initial begin
    reset_n = 1'b1;
    coin_f = 0; coin_h = 0; cancel = 0; vend_ack = 0; hopper_rdy = 1;
    #1 reset_n = 1'b0;
    #2;
    check("reset_dut3", obs3(), mk_obs(0, 0, 0, 0, 0, 0));
    check("reset_dut15", obs15(), mk_obs(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    hopper_rdy = 0;

    // Directed table against the PRICE=3 instance: f h c ack rdy | st cr vreq half far rej
    vq.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0, 1,2,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 2,3,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 2,3,1,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 2,3,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0));
    vq.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(0,1,0,0,0, 1,2,0,0,0,0));
    vq.push_back(mk(0,0,0,1,1, 2,4,1,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 3,1,0,0,1,0));
    vq.push_back(mk(0,0,0,0,1, 3,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(0,0,1,0,0, 1,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 4,1,0,0,1,0));
    vq.push_back(mk(0,0,0,0,1, 4,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0));
    vq.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(0,0,1,0,1, 1,2,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 4,2,0,1,0,0));
    vq.push_back(mk(0,0,0,0,1, 4,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0));
    vq.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(0,1,0,0,0, 1,2,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0, 2,4,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 2,4,1,0,0,1));
    vq.push_back(mk(0,0,0,1,0, 2,4,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 3,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 3,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 3,1,0,0,1,0));
    vq.push_back(mk(0,0,0,0,0, 3,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(0,0,1,1,0, 0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(1,0,1,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1));
    vq.push_back(mk(1,1,0,0,0, 0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 2,3,1,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 2,3,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));
    foreach (vq[i]) begin
      drive(vq[i].f, vq[i].h, vq[i].c, vq[i].ack, vq[i].rdy);
      check($sformatf("vec%0d", i), obs3(), vq[i].exp);
      next_cyc();
    end

    // Overflow rejection at credit 14 on the PRICE=15 instance.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(0,1,0,0,0);
      check($sformatf("fill%0d", k), obs15(), mk_obs((k == 0) ? 0 : 1, 2 * k, 0, 0, 0, 0));
      next_cyc();
    end
    drive(0,1,0,0,0); check("cr14_coin_h", obs15(), mk_obs(1, 14, 0, 0, 0, 0)); next_cyc();
    drive(0,0,0,0,0); check("cr14_reject", obs15(), mk_obs(1, 14, 0, 0, 0, 1)); next_cyc();
    drive(1,0,0,0,0); check("cr14_coin_f", obs15(), mk_obs(1, 14, 0, 0, 0, 0)); next_cyc();
    drive(0,0,0,1,0); check("cr15_vend", obs15(), mk_obs(2, 15, 1, 0, 0, 0)); next_cyc();
    drive(0,0,0,0,0); check("cr15_done", obs15(), mk_obs(0, 0, 0, 0, 0, 0)); next_cyc();

    // Refund of 5 with a 10-cycle hopper stall after the first eject.
    drive(0,1,0,0,0); next_cyc();
    drive(0,1,0,0,0); next_cyc();
    drive(1,0,0,0,0); next_cyc();
    drive(0,0,1,0,0); check("refund_pre", obs15(), mk_obs(1, 5, 0, 0, 0, 0)); next_cyc();
    pcode = 0; last_pc = -100; min_gap = 100; done = 0;
    for (int n = 0; n < 60 && done == 0; n++) begin
      drive(0, 0, 0, 0, (n >= 1 && n <= 10) ? 1'b0 : 1'b1);
      if (o15_half || o15_far) begin
        pcode = pcode * 10 + (o15_half ? 2 : 1);
        if (n - last_pc < min_gap) min_gap = n - last_pc;
        last_pc = n;
      end
      if (n >= 1 && n <= 10) check($sformatf("stall%0d", n), obs15(), mk_obs(4, 3, 0, 0, 0, 0));
      if (o15_st == 4'd0) done = 1;
      next_cyc();
    end
    check_int("refund_done", done, 1);
    check_int("refund_seq", pcode, 221);
    check_int("refund_gap_ok", (min_gap >= 2) ? 1 : 0, 1);

    // Asynchronous reset in the middle of a change payout.
    do_reset();
    drive(0,1,0,0,0); next_cyc();
    drive(0,1,0,0,0); next_cyc();
    drive(0,0,0,1,0); next_cyc();
    drive(0,0,0,0,1); check("change_far", obs3(), mk_obs(3, 1, 0, 0, 1, 0));
    #2 reset_n = 1'b0;
    #1;
    check("arst_dut3", obs3(), mk_obs(0, 0, 0, 0, 0, 0));
    check("arst_dut15", obs15(), mk_obs(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(0,0,0,0,1); check("post_arst", obs3(), mk_obs(0, 0, 0, 0, 0, 0)); next_cyc();

    // Idle credit: refund after timeout when enabled, otherwise credit persists.
    do_reset();
    drive(1,0,0,0,0); next_cyc();
`ifdef VEND_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      drive(0,0,0,0,0); check($sformatf("to_wait%0d", k), obs3(), mk_obs(1, 1, 0, 0, 0, 0)); next_cyc();
    end
    drive(0,0,0,0,1); check("to_refund", obs3(), mk_obs(4, 1, 0, 0, 1, 0)); next_cyc();
    drive(0,0,0,0,1); check("to_paid", obs3(), mk_obs(4, 0, 0, 0, 0, 0)); next_cyc();
    drive(0,0,0,0,1); check("to_idle", obs3(), mk_obs(0, 0, 0, 0, 0, 0)); next_cyc();
`else
    for (int k = 0; k < 20; k++) begin
      drive(0,0,0,0,1); check($sformatf("hold%0d", k), obs3(), mk_obs(1, 1, 0, 0, 0, 0)); next_cyc();
    end
`endif

    // Random run of both instances against the reference model.
    do_reset();
    m3  = '{st: 0, cr: 0, rest: 0, rej: 0, idle: 0};
    m15 = '{st: 0, cr: 0, rest: 0, rej: 0, idle: 0};
    for (int n = 0; n < 3000; n++) begin
      bit f, h, c, a, r;
      f = ($urandom_range(0, 99) < 15);
      h = ($urandom_range(0, 99) < 15);
      c = ($urandom_range(0, 99) < 4);
      a = ($urandom_range(0, 99) < 20);
      r = ($urandom_range(0, 99) < 65);
      drive(f, h, c, a, r);
      check($sformatf("rnd3_%0d", n), obs3(), mdl_out(m3, r));
      check($sformatf("rnd15_%0d", n), obs15(), mdl_out(m15, r));
      next_cyc();
      m3  = mdl_next(m3, f, h, c, a, r, 3);
      m15 = mdl_next(m15, f, h, c, a, r, 15);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
